// File: rtl/gate_tt_checker.sv
// Truth-table sequencer/checker for a two-input gate bank: drives {a,b} through
// 00..11, samples the seven gate outputs after a settle time, and records mismatches.
module gate_tt_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [6:0]  CHECK_MASK    = 7'h7F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       err_valid,
  output logic [1:0] fail_vec,
  output logic [6:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t     state_q;
  logic [1:0] vec_q;
  logic [3:0] cnt_q;
  logic       a_q, b_q, busy_q, done_q, pass_q, err_valid_q;
  logic [4:0] err_count_q, err_count_d;
  logic [1:0] fail_vec_q;
  logic [6:0] fail_mask_q;

  logic [6:0] exp_s;
  logic [6:0] mism_s;
  logic [5:0] sum_s;
  logic [1:0] vec_inc_s;

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // Golden model compare; !== makes X/Z on gate_out count as a mismatch.
  always_comb begin
    exp_s  = {a_q & b_q, a_q | b_q, ~a_q, ~(a_q & b_q), ~(a_q | b_q),
              a_q ^ b_q, ~(a_q ^ b_q)};
    mism_s = 7'b0000000;
    for (int i = 0; i < 7; i++) begin
      mism_s[i] = CHECK_MASK[i] & (gate_out[i] !== exp_s[i]);
    end
    sum_s     = {1'b0, err_count_q} + {3'b000, popcount7(mism_s)};
    vec_inc_s = vec_q + 2'd1;
    if (sum_s > 6'd31) begin
      err_count_d = 5'd31;
    end else begin
      err_count_d = sum_s[4:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= 2'd0;
      cnt_q       <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 5'd0;
      err_valid_q <= 1'b0;
      fail_vec_q  <= 2'd0;
      fail_mask_q <= 7'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= HOLD;
            vec_q       <= 2'd0;
            cnt_q       <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 5'd0;
            err_valid_q <= 1'b0;
            fail_vec_q  <= 2'd0;
            fail_mask_q <= 7'd0;
          end
        end
        HOLD: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q       <= 4'd0;
            err_count_q <= err_count_d;
            // Only the first failing vector is captured.
            if ((mism_s != 7'd0) && !err_valid_q) begin
              fail_vec_q  <= {a_q, b_q};
              fail_mask_q <= mism_s;
              err_valid_q <= 1'b1;
            end
            if (vec_q != 2'd3) begin
              vec_q <= vec_inc_s;
              a_q   <= vec_inc_s[1];
              b_q   <= vec_inc_s[0];
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == 5'd0);
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_valid = err_valid_q;
  assign fail_vec  = fail_vec_q;
  assign fail_mask = fail_mask_q;

endmodule
